// File: rtl/matvec_sched.sv
// matvec_sched: runs a matrix-vector job row by row on one shared dot-product engine
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_rows job command; abort cancels a job;
// eng_start/eng_row/eng_done/eng_result engine handshake; res_valid/res_ready/res_data/
// res_row/res_last result stream; job_done pulse, busy, sticky err_timeout/err_rows.
module matvec_sched #(
  parameter int MAX_ROWS = 16,
  parameter int ROW_W    = 5,
  parameter int RES_W    = 16,
  parameter int TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_rows,
  input  logic             abort,
  output logic             eng_start,
  output logic [ROW_W-1:0] eng_row,
  input  logic             eng_done,
  input  logic [RES_W-1:0] eng_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [RES_W-1:0] res_data,
  output logic [ROW_W-1:0] res_row,
  output logic             res_last,
  output logic             job_done,
  output logic             busy,
  output logic             err_timeout,
  output logic             err_rows
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t           state_q;
  logic [ROW_W-1:0] rows_q, row_q, res_row_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RES_W-1:0] res_data_q;
  logic             cmd_ready_q, eng_start_q, res_valid_q, res_last_q;
  logic             job_done_q, busy_q, err_timeout_q, err_rows_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rows_q        <= '0;
      row_q         <= '0;
      res_row_q     <= '0;
      cnt_q         <= '0;
      res_data_q    <= '0;
      cmd_ready_q   <= 1'b1;
      eng_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      job_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_rows_q    <= 1'b0;
    end else begin
      job_done_q  <= 1'b0;
      eng_start_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE:
            // abort in the same cycle as a command drops the command
            if (cmd_valid && !abort) begin
              if (cmd_rows == '0) job_done_q <= 1'b1;
              else if (cmd_rows > ROW_W'(MAX_ROWS)) err_rows_q <= 1'b1;
              else begin
                rows_q      <= cmd_rows;
                row_q       <= '0;
                eng_start_q <= 1'b1;
                cmd_ready_q <= 1'b0;
                busy_q      <= 1'b1;
                state_q     <= ISSUE;
              end
            end
          ISSUE: begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
          WAIT:
            // done takes priority over a timeout in the same cycle
            if (eng_done) begin
              res_data_q  <= eng_result;
              res_row_q   <= row_q;
              res_last_q  <= row_q == rows_q - ROW_W'(1);
              res_valid_q <= 1'b1;
              state_q     <= OUT;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
              err_timeout_q <= 1'b1;
              cmd_ready_q   <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= IDLE;
            end else cnt_q <= cnt_q + CNT_W'(1);
          OUT:
            if (res_ready) begin
              res_valid_q <= 1'b0;
              if (res_last_q) begin
                job_done_q  <= 1'b1;
                cmd_ready_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end else begin
                row_q       <= row_q + ROW_W'(1);
                eng_start_q <= 1'b1;
                state_q     <= ISSUE;
              end
            end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign cmd_ready   = cmd_ready_q;
  assign eng_start   = eng_start_q;
  assign eng_row     = row_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_row     = res_row_q;
  assign res_last    = res_last_q;
  assign job_done    = job_done_q;
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign err_rows    = err_rows_q;
endmodule
